// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder.
//   ADD_OP/SUB_OP/ADC_OP/SBB_OP : operation encodings on in_op
//   op_ctrl_t / op_ctrl()       : per-op operand inversion and carry-in
package adder_pkg;

  localparam logic [1:0] ADD_OP = 2'b00;
  localparam logic [1:0] SUB_OP = 2'b01;
  localparam logic [1:0] ADC_OP = 2'b10;
  localparam logic [1:0] SBB_OP = 2'b11;

  // invert_b selects b_eff = ~b; c0 is the carry into bit 0.
  typedef struct packed {
    logic invert_b;
    logic c0;
  } op_ctrl_t;

  function automatic op_ctrl_t op_ctrl(input logic [1:0] op, input logic cin);
    op_ctrl_t ctrl;
    case (op)
      ADD_OP:  ctrl = '{invert_b: 1'b0, c0: 1'b0};
      SUB_OP:  ctrl = '{invert_b: 1'b1, c0: 1'b1};
      ADC_OP:  ctrl = '{invert_b: 1'b0, c0: cin};
      SBB_OP:  ctrl = '{invert_b: 1'b1, c0: cin};
      default: ctrl = '{invert_b: 1'b0, c0: 1'b0};
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/adder_slice_stage.sv
// One pipeline stage of the pipelined adder: adds slice IDX of the operands
// using the carry handed over by the previous stage, and registers the
// result together with the forwarded operands and partial sum.
//   up_*  : upstream side (valid/ready, operands, partial sum, carry, zero bits)
//   dn_*  : downstream side (registered copies of the same, with slice IDX done)
module adder_slice_stage #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int IDX    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [WIDTH-1:0]  up_a,
  input  logic [WIDTH-1:0]  up_b,
  input  logic [WIDTH-1:0]  up_sum,
  input  logic              up_carry,
  input  logic [STAGES-1:0] up_zero,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [WIDTH-1:0]  dn_a,
  output logic [WIDTH-1:0]  dn_b,
  output logic [WIDTH-1:0]  dn_sum,
  output logic              dn_carry,
  output logic [STAGES-1:0] dn_zero
);

  localparam int S = WIDTH / STAGES;

  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [STAGES-1:0] zero_q, zero_d;
  logic [S:0]        slice_res;

  // Accept when empty or when the held entry leaves this cycle (bubble squeeze).
  assign up_ready = !valid_q || dn_ready;

  always_comb begin
    slice_res = {1'b0, up_a[IDX*S +: S]} + {1'b0, up_b[IDX*S +: S]} + {{S{1'b0}}, up_carry};
  end

  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (up_ready) begin
      valid_d = up_valid;
      if (up_valid) begin
        a_d                = up_a;
        b_d                = up_b;
        sum_d              = up_sum;
        sum_d[IDX*S +: S]  = slice_res[S-1:0];
        carry_d            = slice_res[S];
        zero_d             = up_zero;
        zero_d[IDX]        = (slice_res[S-1:0] == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign dn_valid = valid_q;
  assign dn_a     = a_q;
  assign dn_b     = b_q;
  assign dn_sum   = sum_q;
  assign dn_carry = carry_q;
  assign dn_zero  = zero_q;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/sub with carry, overflow and zero flags. The carry
// chain is cut into STAGES slices, one per register stage; latency STAGES,
// throughput one per cycle, valid/ready handshake with full backpressure.
//   clk, rst_n              : clock, async active-low reset
//   in_valid/in_ready       : input handshake
//   in_a, in_b, in_op, in_cin : operands, operation (ADD/SUB/ADC/SBB), carry-in
//   out_valid/out_ready     : output handshake
//   out_sum, out_cout, out_ovf, out_zero : result and flags
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  op_ctrl_t         ctrl;
  logic [WIDTH-1:0] b_eff;

  assign ctrl  = op_ctrl(in_op, in_cin);
  assign b_eff = in_b ^ {WIDTH{ctrl.invert_b}};

  // Each stage owns its own link signals so the ready chain is not one
  // shared vector feeding back on itself.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic              up_valid, up_ready, up_carry, dn_ready;
    logic [WIDTH-1:0]  up_a, up_b, up_sum;
    logic [STAGES-1:0] up_zero;
    logic              dn_valid, dn_carry;
    logic [WIDTH-1:0]  dn_a, dn_b, dn_sum;
    logic [STAGES-1:0] dn_zero;

    if (k == 0) begin : g_src
      assign up_valid = in_valid;
      assign up_a     = in_a;
      assign up_b     = b_eff;
      assign up_sum   = '0;
      assign up_carry = ctrl.c0;
      assign up_zero  = '0;
    end else begin : g_src
      assign up_valid = g_stage[k-1].dn_valid;
      assign up_a     = g_stage[k-1].dn_a;
      assign up_b     = g_stage[k-1].dn_b;
      assign up_sum   = g_stage[k-1].dn_sum;
      assign up_carry = g_stage[k-1].dn_carry;
      assign up_zero  = g_stage[k-1].dn_zero;
    end

    if (k == STAGES - 1) begin : g_snk
      assign dn_ready = out_ready;
    end else begin : g_snk
      assign dn_ready = g_stage[k+1].up_ready;
    end

    adder_slice_stage #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .IDX    (k)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (up_valid),
      .up_ready (up_ready),
      .up_a     (up_a),
      .up_b     (up_b),
      .up_sum   (up_sum),
      .up_carry (up_carry),
      .up_zero  (up_zero),
      .dn_valid (dn_valid),
      .dn_ready (dn_ready),
      .dn_a     (dn_a),
      .dn_b     (dn_b),
      .dn_sum   (dn_sum),
      .dn_carry (dn_carry),
      .dn_zero  (dn_zero)
    );
  end

  logic [WIDTH-1:0]  last_a, last_b;
  logic [STAGES-1:0] last_zero;
  logic              unused_low_operands;

  assign in_ready  = g_stage[0].up_ready;
  assign out_valid = g_stage[STAGES-1].dn_valid;
  assign out_sum   = g_stage[STAGES-1].dn_sum;
  assign out_cout  = g_stage[STAGES-1].dn_carry;
  assign last_a    = g_stage[STAGES-1].dn_a;
  assign last_b    = g_stage[STAGES-1].dn_b;
  assign last_zero = g_stage[STAGES-1].dn_zero;

  // Flags come straight off the final register; reset state gives all zeros.
  assign out_zero = &last_zero;
  assign out_ovf  = (last_a[WIDTH-1] == last_b[WIDTH-1]) && (out_sum[WIDTH-1] != last_a[WIDTH-1]);

  // Only the sign bits of the forwarded operands matter after the last slice.
  assign unused_low_operands = ^{last_a[WIDTH-2:0], last_b[WIDTH-2:0]};

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;
  import adder_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Main instance: WIDTH=32, STAGES=2
  logic        m_in_valid, m_in_ready, m_in_cin, m_out_valid, m_out_ready;
  logic        m_out_cout, m_out_ovf, m_out_zero;
  logic [31:0] m_in_a, m_in_b, m_out_sum;
  logic [1:0]  m_in_op;

  // WIDTH=16, STAGES=4
  logic        w_in_valid, w_in_ready, w_in_cin, w_out_valid, w_out_ready;
  logic        w_out_cout, w_out_ovf, w_out_zero;
  logic [15:0] w_in_a, w_in_b, w_out_sum;
  logic [1:0]  w_in_op;

  // WIDTH=32, STAGES=1
  logic        s_in_valid, s_in_ready, s_in_cin, s_out_valid, s_out_ready;
  logic        s_out_cout, s_out_ovf, s_out_zero;
  logic [31:0] s_in_a, s_in_b, s_out_sum;
  logic [1:0]  s_in_op;

  pipelined_adder #(.WIDTH(32), .STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_a(m_in_a), .in_b(m_in_b), .in_op(m_in_op), .in_cin(m_in_cin),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_sum(m_out_sum), .out_cout(m_out_cout), .out_ovf(m_out_ovf), .out_zero(m_out_zero)
  );

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_w16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_a(w_in_a), .in_b(w_in_b), .in_op(w_in_op), .in_cin(w_in_cin),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_sum(w_out_sum), .out_cout(w_out_cout), .out_ovf(w_out_ovf), .out_zero(w_out_zero)
  );

  pipelined_adder #(.WIDTH(32), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_op(s_in_op), .in_cin(s_in_cin),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_sum(s_out_sum), .out_cout(s_out_cout), .out_ovf(s_out_ovf), .out_zero(s_out_zero)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs[14];

  // Single transaction on the main instance; lat = edges until out_valid.
  task automatic run_main(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, output int lat);
    @(negedge clk);
    m_in_op = op; m_in_a = a; m_in_b = b; m_in_cin = cin; m_in_valid = 1'b1;
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    lat = 1;
    while (!m_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int sent, rcvd, cyc;
    logic        stall_prev;
    logic [31:0] held_sum;
    logic        held_cout;
    bit          pat[4];

    vecs[0]  = '{ADD_OP, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{SUB_OP, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{SUB_OP, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{ADD_OP, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{ADC_OP, 32'h0000_FFFF, 32'h0000_0001, 1'b1, 32'h0001_0001, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{ADC_OP, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{SBB_OP, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{SBB_OP, 32'h0000_000A, 32'h0000_0003, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{ADD_OP, 32'h0000_0002, 32'h0000_0003, 1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{SUB_OP, 32'h0000_0009, 32'h0000_0009, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{ADD_OP, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{ADD_OP, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{SBB_OP, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{SUB_OP, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};

    m_in_valid = 1'b0; m_in_a = '0; m_in_b = '0; m_in_op = ADD_OP; m_in_cin = 1'b0; m_out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_in_op = ADD_OP; w_in_cin = 1'b0; w_out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_op = ADD_OP; s_in_cin = 1'b0; s_out_ready = 1'b1;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("reset_outputs", 64'({m_out_valid, m_out_sum, m_out_cout, m_out_ovf, m_out_zero}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", 64'(m_in_ready), 64'd1);

    // Table-driven single transactions on the 32/2 instance
    for (int i = 0; i < 14; i++) begin
      run_main(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      check($sformatf("vec%0d_result", i),
            64'({m_out_sum, m_out_cout, m_out_ovf, m_out_zero}),
            64'({vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].zero}));
    end

    // 16-bit, 4 stages: carry ripples through every slice
    @(negedge clk);
    w_in_op = ADC_OP; w_in_a = 16'hFFFF; w_in_b = 16'h0000; w_in_cin = 1'b1; w_in_valid = 1'b1;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    lat = 1;
    while (!w_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w16_latency", 64'(lat), 64'd4);
    check("w16_result", 64'({w_out_sum, w_out_cout, w_out_ovf, w_out_zero}),
          64'({16'h0000, 1'b1, 1'b0, 1'b1}));

    // 32-bit, single stage
    @(negedge clk);
    s_in_op = SBB_OP; s_in_a = 32'h0; s_in_b = 32'h0; s_in_cin = 1'b0; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    lat = 1;
    while (!s_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("s1_latency", 64'(lat), 64'd1);
    check("s1_result", 64'({s_out_sum, s_out_cout, s_out_ovf, s_out_zero}),
          64'({32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}));

    // Stream of 8 ADDs under a 1,0,0,1 out_ready pattern
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    sent = 0; rcvd = 0; cyc = 0;
    stall_prev = 1'b0; held_sum = '0; held_cout = 1'b0;
    while (rcvd < 8 && cyc < 100) begin
      @(negedge clk);
      m_out_ready = pat[cyc % 4];
      if (sent < 8) begin
        m_in_valid = 1'b1; m_in_op = ADD_OP; m_in_cin = 1'b0;
        m_in_a = 32'(sent); m_in_b = 32'(sent);
      end else begin
        m_in_valid = 1'b0;
      end
      #1;
      if (stall_prev)
        check("stall_hold", 64'({m_out_valid, m_out_sum, m_out_cout}), 64'({1'b1, held_sum, held_cout}));
      check("stream_in_ready", 64'(m_in_ready), 64'(!((sent - rcvd) == 2 && !m_out_ready)));
      if (m_out_valid && m_out_ready) begin
        check("stream_data", 64'(m_out_sum), 64'(32'(2 * rcvd)));
        rcvd++;
      end
      stall_prev = m_out_valid && !m_out_ready;
      held_sum   = m_out_sum;
      held_cout  = m_out_cout;
      if (m_in_valid && m_in_ready) sent++;
      cyc++;
    end
    check("stream_count", 64'(rcvd), 64'd8);
    @(negedge clk);
    m_in_valid = 1'b0; m_out_ready = 1'b1;
    @(posedge clk); #1;
    check("stream_drained", 64'(m_out_valid), 64'd0);

    // Asynchronous reset with two transactions in flight
    @(negedge clk);
    m_out_ready = 1'b0;
    m_in_valid = 1'b1; m_in_op = ADD_OP; m_in_cin = 1'b0; m_in_a = 32'd100; m_in_b = 32'd1;
    @(posedge clk); #1;
    m_in_a = 32'd200; m_in_b = 32'd2;
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    check("pre_reset_valid", 64'({m_out_valid, m_out_sum}), 64'({1'b1, 32'd101}));
    #2 rst_n = 1'b0;
    #1;
    check("midreset_outputs", 64'({m_out_valid, m_out_sum, m_out_cout, m_out_ovf, m_out_zero}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_out_ready = 1'b1;
    run_main(ADD_OP, 32'd3, 32'd4, 1'b0, lat);
    check("post_reset_latency", 64'(lat), 64'd2);
    check("post_reset_result", 64'({m_out_sum, m_out_cout, m_out_ovf, m_out_zero}),
          64'({32'd7, 1'b0, 1'b0, 1'b0}));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("no_stale_output", 64'(m_out_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
